// File: rtl/time_set_ctrl.sv
// Time-of-day sequencer: scans the sec/min/hr counters over a shared bus, issues carry advances,
// and runs the set-mode read-modify-write. Optional macro AUTO_EXIT_EN adds an inactivity timeout.
module time_set_ctrl #(
  parameter int HR_MAX  = 23,
  parameter int MS_MAX  = 59,
  parameter int TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] databus,
  output logic [2:0] rd_en,
  output logic [2:0] ld,
  output logic [2:0] adv,
  output logic [5:0] data,
  output logic [1:0] mode,
  output logic       busy
);

  typedef enum logic [1:0] {RMW_IDLE, RMW_RD, RMW_WR} rmw_e;
  typedef enum logic [1:0] {M_RUN, M_SET_HR, M_SET_MIN, M_SET_SEC} mode_e;

  localparam logic [5:0] HR_MAX_W = 6'(HR_MAX);
  localparam logic [5:0] MS_MAX_W = 6'(MS_MAX);

  rmw_e        rmw_q, rmw_d;
  mode_e       mode_q, mode_d;
  logic [1:0]  scan_q, scan_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic [5:0]  tmp_q, tmp_d;
  logic [2:0]  adv_q, adv_d;

  logic        in_set, idle, mode_acc, inc_acc, to_expire, exit_now;
  logic        sec_at_max, min_at_max;
  logic [2:0]  sel_oh;
  logic [5:0]  sel_max, wr_val;

  // +1 in 7 bits; anything at or above the wrap value (including 60..63) loads 0
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    logic [6:0] sum;
    sum = {1'b0, v} + 7'd1;
    return ({1'b0, v} >= {1'b0, max}) ? 6'd0 : sum[5:0];
  endfunction

  assign in_set     = (mode_q != M_RUN);
  assign idle       = (rmw_q == RMW_IDLE);
  assign mode_acc   = btn_mode && idle;
  assign inc_acc    = btn_inc && idle && in_set && !btn_mode && !to_expire;
  assign exit_now   = to_expire && idle;
  assign sec_at_max = (sec_q == MS_MAX_W);
  assign min_at_max = (min_q == MS_MAX_W);
  assign wr_val     = wrap_inc(tmp_q, sel_max);

  always_comb begin
    sel_oh  = 3'b000;
    sel_max = MS_MAX_W;
    case (mode_q)
      M_SET_HR:  begin sel_oh = 3'b100; sel_max = HR_MAX_W; end
      M_SET_MIN: sel_oh = 3'b010;
      M_SET_SEC: sel_oh = 3'b001;
      default:   sel_oh = 3'b000;
    endcase
  end

`ifdef AUTO_EXIT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (mode_acc || inc_acc)
      to_cnt_d = '0;
    else if (in_set && tick_1hz && (to_cnt_q < TW'(TIMEOUT)))
      to_cnt_d = to_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  // Saturated count holds the exit request until the RMW finishes
  assign to_expire = in_set && ((to_cnt_q >= TW'(TIMEOUT)) ||
                                (tick_1hz && (to_cnt_q == TW'(TIMEOUT - 1))));
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    rmw_d  = rmw_q;
    mode_d = mode_q;
    scan_d = scan_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    tmp_d  = tmp_q;
    adv_d  = 3'b000;

    // Time is frozen in any SET state, so ticks only advance in RUN
    if (!in_set && tick_1hz)
      adv_d = {sec_at_max && min_at_max, sec_at_max, 1'b1};

    if (mode_acc)      mode_d = mode_e'(mode_q + 2'd1);
    else if (exit_now) mode_d = M_RUN;

    unique case (rmw_q)
      RMW_IDLE: begin
        scan_d = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
        case (scan_q)
          2'd0:    sec_d = databus;
          2'd1:    min_d = databus;
          default: hr_d  = databus;
        endcase
        if (inc_acc) rmw_d = RMW_RD;
      end
      RMW_RD: begin
        tmp_d = databus;
        rmw_d = RMW_WR;
      end
      RMW_WR: begin
        scan_d = 2'd0;
        rmw_d  = RMW_IDLE;
        case (mode_q)
          M_SET_HR:  hr_d  = wr_val;
          M_SET_MIN: min_d = wr_val;
          M_SET_SEC: sec_d = wr_val;
          default:   hr_d  = hr_q;
        endcase
      end
      default: rmw_d = RMW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rmw_q  <= RMW_IDLE;
      mode_q <= M_RUN;
      scan_q <= 2'd0;
      sec_q  <= 6'd0;
      min_q  <= 6'd0;
      hr_q   <= 6'd0;
      adv_q  <= 3'b000;
    end else begin
      rmw_q  <= rmw_d;
      mode_q <= mode_d;
      scan_q <= scan_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      adv_q  <= adv_d;
    end
  end

  always_ff @(posedge clk) begin
    tmp_q <= tmp_d;
  end

  // During WR nothing drives the bus so the loaded counter sees no contention
  always_comb begin
    rd_en = 3'b000;
    ld    = 3'b000;
    data  = 6'd0;
    case (rmw_q)
      RMW_IDLE: rd_en = 3'b001 << scan_q;
      RMW_RD:   rd_en = sel_oh;
      RMW_WR: begin
        ld   = sel_oh;
        data = wr_val;
      end
      default: rd_en = 3'b000;
    endcase
  end

  assign busy = !idle;
  assign adv  = adv_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: models the three counters on the bus, drives random button/tick
// traffic, and scores adv/ld events against a time-of-day reference model.
module tb_time_set_ctrl;

  localparam int HMAX = 23;
  localparam int MMAX = 59;
  localparam int TO   = 10;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] databus;
  logic [2:0] rd_en, ld, adv;
  logic [5:0] data;
  logic [1:0] mode;
  logic       busy;

  time_set_ctrl #(.HR_MAX(HMAX), .MS_MAX(MMAX), .TIMEOUT(TO)) dut (
    .clk(clk), .clear(clear), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .databus(databus), .rd_en(rd_en), .ld(ld), .adv(adv),
    .data(data), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter environment: three unit counters on a wired-OR bus
  logic [5:0] env_s = 6'd0, env_m = 6'd0, env_h = 6'd0;
  logic       poke_en = 1'b0;
  logic [1:0] poke_sel = 2'd0;
  logic [5:0] poke_val = 6'd0;

  assign databus = (rd_en[0] ? env_s : 6'd0) | (rd_en[1] ? env_m : 6'd0) | (rd_en[2] ? env_h : 6'd0);

  function automatic int winc(input int v, input int mx);
    return (v >= mx) ? 0 : v + 1;
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      case (poke_sel)
        2'd0:    env_s <= poke_val;
        2'd1:    env_m <= poke_val;
        default: env_h <= poke_val;
      endcase
    end else begin
      if (ld[0]) env_s <= data; else if (adv[0]) env_s <= 6'(winc(env_s, MMAX));
      if (ld[1]) env_m <= data; else if (adv[1]) env_m <= 6'(winc(env_m, MMAX));
      if (ld[2]) env_h <= data; else if (adv[2]) env_h <= 6'(winc(env_h, HMAX));
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [2:0] adv;
    logic [2:0] ld;
    logic [5:0] data;
  } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !clear && ((adv != 3'b000) || (ld != 3'b000))) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got adv=%b ld=%b data=%0d expected none at %0t", adv, ld, data, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_adv", int'(adv), int'(e.adv));
        chk("ev_ld", int'(ld), int'(e.ld));
        chk("ev_data", int'(data), int'(e.data));
      end
    end
  end

  // Reference model: wall-clock time and user mode
  int ms = 0, mn = 0, mh = 0, mm = 0, to_cnt = 0;

  task automatic model_tick();
    ev_t e;
    bit c1, c2;
    if (mm == 0) begin
      c1 = (ms == MMAX);
      c2 = c1 && (mn == MMAX);
      e.adv = {c2, c1, 1'b1};
      e.ld = 3'b000;
      e.data = 6'd0;
      exp_q.push_back(e);
      ms = winc(ms, MMAX);
      if (c1) mn = winc(mn, MMAX);
      if (c2) mh = winc(mh, HMAX);
    end else begin
`ifdef AUTO_EXIT_EN
      to_cnt++;
      if (to_cnt >= TO) mm = 0;
`endif
    end
  endtask

  task automatic model_inc();
    ev_t e;
    if (mm != 0) begin
      e.adv = 3'b000;
      case (mm)
        1: begin mh = winc(mh, HMAX); e.ld = 3'b100; e.data = 6'(mh); end
        2: begin mn = winc(mn, MMAX); e.ld = 3'b010; e.data = 6'(mn); end
        default: begin ms = winc(ms, MMAX); e.ld = 3'b001; e.data = 6'(ms); end
      endcase
      exp_q.push_back(e);
      to_cnt = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input bit m, input bit i, input bit t);
    if (t) model_tick();
    if (m) begin
      mm = (mm + 1) % 4;
      to_cnt = 0;
    end else if (i) model_inc();
    btn_mode = m;
    btn_inc = i;
    tick_1hz = t;
    cyc();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic poke(input int sel, input int val);
    poke_en = 1'b1;
    poke_sel = 2'(sel);
    poke_val = 6'(val);
    cyc();
    poke_en = 1'b0;
    case (sel)
      0: ms = val;
      1: mn = val;
      default: mh = val;
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_mode"}, int'(mode), mm);
    chk({tag, "_sec"}, int'(env_s), ms);
    chk({tag, "_min"}, int'(env_m), mn);
    chk({tag, "_hr"}, int'(env_h), mh);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  logic [2:0] exp_rd [3] = '{3'b001, 3'b010, 3'b100};

  initial begin
    cyc();
    cyc();
    clear = 1'b0;
    mon_on = 1'b1;

    // Post-reset scan order and quiet outputs
    for (int i = 0; i < 6; i++) begin
      chk("rst_rd_en", int'(rd_en), int'(exp_rd[i % 3]));
      chk("rst_ld", int'(ld), 0);
      chk("rst_adv", int'(adv), 0);
      chk("rst_mode", int'(mode), 0);
      if (i < 5) cyc();
    end
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(data), 0);

    // Full carry on 59:59
    poke(0, 59); poke(1, 59); poke(2, 5);
    gap(4);
    press(0, 0, 1);
    chk("adv_carry", int'(adv), 3'b111);
    cyc();
    chk("adv_one_wide", int'(adv), 0);
    gap(8);
    check_state("carry");

    // SET_HR increment of 23 wraps to 0
    press(1, 0, 0);
    chk("set_hr_mode", int'(mode), 1);
    poke(2, 23);
    gap(4);
    press(0, 1, 0);
    chk("rd_rd_en", int'(rd_en), 3'b100);
    chk("rd_busy", int'(busy), 1);
    chk("rd_ld", int'(ld), 0);
    cyc();
    chk("wr_ld", int'(ld), 3'b100);
    chk("wr_data", int'(data), 0);
    chk("wr_busy", int'(busy), 1);
    cyc();
    chk("post_busy", int'(busy), 0);
    chk("post_rd_en", int'(rd_en), 3'b001);
    gap(8);
    check_state("set_hr");

    // SET_MIN 41 -> 42, tick frozen
    press(1, 0, 0);
    poke(1, 41);
    gap(4);
    press(0, 1, 0);
    gap(4);
    press(0, 0, 1);
    chk("frozen_adv", int'(adv), 0);
    gap(8);
    check_state("set_min");

    // Out-of-range seconds load 0
    press(1, 0, 0);
    poke(0, 62);
    gap(4);
    press(0, 1, 0);
    gap(8);
    check_state("set_sec_oor");
    press(1, 0, 0);
    gap(8);

    // Mode beats increment from RUN
    press(1, 1, 0);
    chk("both_busy", int'(busy), 0);
    chk("both_mode", int'(mode), 1);
    gap(8);
    check_state("both");

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: press(0, 0, 1);
        3: press(1, 0, 0);
        4: press(0, 1, 0);
        5: press(1, 1, 0);
`ifndef AUTO_EXIT_EN
        6: press(1, 0, 1);
`endif
        7: poke($urandom_range(0, 2), $urandom_range(0, 63));
        8: begin
          if (mm != 0) begin
            press(0, 1, 0);
            btn_inc = 1'b1;
            cyc();
            btn_inc = 1'b0;
            btn_mode = 1'b1;
            cyc();
            btn_mode = 1'b0;
          end else press(0, 0, 1);
        end
        default: press(0, 1, 1);
      endcase
      gap(9);
      check_state("rand");
    end

`ifdef AUTO_EXIT_EN
    while (mm != 0) begin press(1, 0, 0); gap(8); end
    press(1, 0, 0);
    gap(8);
    for (int k = 1; k <= TO; k++) begin
      press(0, 0, 1);
      if (k < TO) chk("auto_hold", int'(mode), 1);
      else        chk("auto_exit", int'(mode), 0);
      gap(8);
    end
    check_state("auto");
`endif

    // Clear during RD aborts the write
    while (mm == 0) begin press(1, 0, 0); gap(8); end
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
    chk("abort_rd_busy", int'(busy), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    mm = 0;
    to_cnt = 0;
    chk("abort_rd_en", int'(rd_en), 3'b001);
    chk("abort_ld", int'(ld), 0);
    chk("abort_adv", int'(adv), 0);
    chk("abort_data", int'(data), 0);
    chk("abort_mode", int'(mode), 0);
    chk("abort_busy", int'(busy), 0);
    gap(9);
    check_state("abort");

    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
